// File: rtl/tri_inv_seq.sv
// tri_inv_seq: job sequencer and single-port row-RAM arbiter for the
// triangular matrix inverter. Rows 0..SIZE-1 of the RAM hold the input
// matrix and rows SIZE..2*SIZE-1 hold the inverse columns.
module tri_inv_seq #(
  parameter int SIZE  = 16,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(2*SIZE),
  localparam int RW   = SIZE*2*WIDTH,
  localparam int IW   = $clog2(SIZE)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          job_go_i,
  input  logic          job_flush_i,
  output logic          job_done_o,
  output logic [1:0]    job_state_o,
  output logic          err_o,
  input  logic          host_wr_valid_i,
  input  logic [IW-1:0] host_wr_addr_i,
  input  logic [RW-1:0] host_wr_data_i,
  input  logic          host_rd_valid_i,
  input  logic [IW-1:0] host_rd_addr_i,
  output logic [RW-1:0] host_rd_data_o,
  output logic          host_rd_data_valid_o,
  input  logic          job_ack_i,
  output logic          inv_start_o,
  output logic          inv_flush_o,
  output logic          inv_out_ready_o,
  input  logic [IW-1:0] inv_row_req_addr_i,
  input  logic          inv_row_req_valid_i,
  output logic [RW-1:0] mat_row_o,
  output logic [IW-1:0] mat_row_addr_o,
  output logic          mat_row_valid_o,
  input  logic [RW-1:0] inv_col_i,
  input  logic [IW-1:0] inv_col_addr_i,
  input  logic          inv_col_valid_i,
  input  logic          inv_busy_i,
  output logic          ram_en_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [RW-1:0] ram_wdata_o,
  input  logic [RW-1:0] ram_rdata_i
);

  localparam int CW = $clog2(SIZE) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [SIZE-1:0] mask;
  logic [SIZE-1:0] mask_next;
  logic [CW-1:0]   col_cnt;

  // Writeback slot (one column) and row-fetch slot (one address)
  logic            wb_full;
  logic [IW-1:0]   wb_addr;
  logic [RW-1:0]   wb_data;
  logic            rd_full;
  logic [IW-1:0]   rd_addr;

  // Reads in flight: RAM data arrives the cycle after the read enable
  logic            rd_issue;
  logic [IW-1:0]   rd_issue_addr;
  logic            host_rd_issue;

  logic            clear_job;
  logic            err_set;
  logic            start_set;
  logic            wb_capture;
  logic            wb_drain;
  logic            rd_capture;
  logic            rd_drain;
  logic            host_rd_go;

  assign job_state_o     = state;
  assign job_done_o      = (state == DONE);
  assign inv_out_ready_o = (state == RUN) && !wb_full;

  // Next-state, RAM port arbitration and protocol-error detection
  always_comb begin
    state_next  = state;
    mask_next   = mask;
    clear_job   = 1'b0;
    err_set     = 1'b0;
    start_set   = 1'b0;
    wb_capture  = 1'b0;
    wb_drain    = 1'b0;
    rd_capture  = 1'b0;
    rd_drain    = 1'b0;
    host_rd_go  = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (job_flush_i) begin
      state_next = IDLE;
      mask_next  = '0;
      clear_job  = 1'b1;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (host_wr_valid_i) begin
            ram_en_o    = 1'b1;
            ram_we_o    = 1'b1;
            ram_addr_o  = AW'(host_wr_addr_i);
            ram_wdata_o = host_wr_data_i;
            mask_next[host_wr_addr_i] = 1'b1;
            if (state == IDLE) state_next = LOAD;
          end
          if ((state == LOAD) && job_go_i) begin
            if (&mask) begin
              state_next = RUN;
              start_set  = 1'b1;
            end else begin
              err_set = 1'b1;
            end
          end
        end
        RUN: begin
          if (wb_full) begin
            ram_en_o    = 1'b1;
            ram_we_o    = 1'b1;
            ram_addr_o  = AW'(SIZE) + AW'(wb_addr);
            ram_wdata_o = wb_data;
            wb_drain    = 1'b1;
          end else if (rd_full) begin
            ram_en_o   = 1'b1;
            ram_addr_o = AW'(rd_addr);
            rd_drain   = 1'b1;
          end
          wb_capture = inv_col_valid_i && !wb_full;
          if (inv_row_req_valid_i) begin
            if (rd_full) err_set = 1'b1;
            else         rd_capture = 1'b1;
          end
          if ((col_cnt == CW'(SIZE)) && !inv_busy_i) state_next = DONE;
        end
        DONE: begin
          if (host_rd_valid_i) begin
            ram_en_o   = 1'b1;
            ram_addr_o = AW'(SIZE) + AW'(host_rd_addr_i);
            host_rd_go = 1'b1;
          end
          if (job_ack_i) begin
            state_next = IDLE;
            mask_next  = '0;
            clear_job  = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
      if (host_wr_valid_i && (state != IDLE) && (state != LOAD)) err_set = 1'b1;
      if (host_rd_valid_i && (state != DONE)) err_set = 1'b1;
      if (inv_col_valid_i && (state != RUN)) err_set = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_next;
  end

  // Loaded mask, column counter, pending slots and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mask                 <= '0;
      col_cnt              <= '0;
      wb_full              <= 1'b0;
      wb_addr              <= '0;
      wb_data              <= '0;
      rd_full              <= 1'b0;
      rd_addr              <= '0;
      rd_issue             <= 1'b0;
      rd_issue_addr        <= '0;
      host_rd_issue        <= 1'b0;
      mat_row_o            <= '0;
      mat_row_addr_o       <= '0;
      mat_row_valid_o      <= 1'b0;
      host_rd_data_o       <= '0;
      host_rd_data_valid_o <= 1'b0;
      inv_start_o          <= 1'b0;
      inv_flush_o          <= 1'b0;
      err_o                <= 1'b0;
    end else begin
      mask <= mask_next;
      if (clear_job) begin
        col_cnt  <= '0;
        wb_full  <= 1'b0;
        rd_full  <= 1'b0;
        rd_issue <= 1'b0;
      end else begin
        if (wb_capture) begin
          wb_full <= 1'b1;
          wb_addr <= inv_col_addr_i;
          wb_data <= inv_col_i;
        end else if (wb_drain) begin
          wb_full <= 1'b0;
        end
        if (wb_drain) col_cnt <= col_cnt + CW'(1);
        if (rd_capture) begin
          rd_full <= 1'b1;
          rd_addr <= inv_row_req_addr_i;
        end else if (rd_drain) begin
          rd_full <= 1'b0;
        end
        rd_issue      <= rd_drain;
        rd_issue_addr <= rd_addr;
      end
      mat_row_valid_o <= rd_issue && !job_flush_i;
      if (rd_issue) begin
        mat_row_o      <= ram_rdata_i;
        mat_row_addr_o <= rd_issue_addr;
      end
      host_rd_issue        <= host_rd_go;
      host_rd_data_valid_o <= host_rd_issue;
      if (host_rd_issue) host_rd_data_o <= ram_rdata_i;
      inv_start_o <= start_set;
      inv_flush_o <= job_flush_i && (state == RUN);
      if (err_set) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tri_inv_seq.sv
// tb_tri_inv_seq: directed bench for tri_inv_seq (SIZE=4, WIDTH=8) with a
// behavioural RAM, a scripted inverter and scoreboard queues of expected
// RAM writes, fetched rows and host read data.
module tb_tri_inv_seq;

  localparam int SIZE  = 4;
  localparam int WIDTH = 8;
  localparam int RW    = SIZE*2*WIDTH;
  localparam int AW    = $clog2(2*SIZE);
  localparam int IW    = $clog2(SIZE);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          job_go_i, job_flush_i, job_done_o, err_o, job_ack_i;
  logic [1:0]    job_state_o;
  logic          host_wr_valid_i, host_rd_valid_i, host_rd_data_valid_o;
  logic [IW-1:0] host_wr_addr_i, host_rd_addr_i;
  logic [RW-1:0] host_wr_data_i, host_rd_data_o;
  logic          inv_start_o, inv_flush_o, inv_out_ready_o;
  logic [IW-1:0] inv_row_req_addr_i, mat_row_addr_o, inv_col_addr_i;
  logic          inv_row_req_valid_i, mat_row_valid_o, inv_col_valid_i, inv_busy_i;
  logic [RW-1:0] mat_row_o, inv_col_i;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [RW-1:0] ram_wdata_o, ram_rdata_i;

  typedef struct {
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t          exp_wr[$];
  exp_t          exp_row[$];
  exp_t          exp_rd[$];
  logic [RW-1:0] rows [SIZE];
  logic [RW-1:0] mem [2*SIZE];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            start_cnt = 0;
  int            flush_cnt = 0;

  tri_inv_seq #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .job_go_i(job_go_i), .job_flush_i(job_flush_i),
    .job_done_o(job_done_o), .job_state_o(job_state_o), .err_o(err_o),
    .host_wr_valid_i(host_wr_valid_i), .host_wr_addr_i(host_wr_addr_i),
    .host_wr_data_i(host_wr_data_i),
    .host_rd_valid_i(host_rd_valid_i), .host_rd_addr_i(host_rd_addr_i),
    .host_rd_data_o(host_rd_data_o), .host_rd_data_valid_o(host_rd_data_valid_o),
    .job_ack_i(job_ack_i),
    .inv_start_o(inv_start_o), .inv_flush_o(inv_flush_o),
    .inv_out_ready_o(inv_out_ready_o),
    .inv_row_req_addr_i(inv_row_req_addr_i), .inv_row_req_valid_i(inv_row_req_valid_i),
    .mat_row_o(mat_row_o), .mat_row_addr_o(mat_row_addr_o),
    .mat_row_valid_o(mat_row_valid_o),
    .inv_col_i(inv_col_i), .inv_col_addr_i(inv_col_addr_i),
    .inv_col_valid_i(inv_col_valid_i), .inv_busy_i(inv_busy_i),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  // Behavioural single-port RAM with one-cycle read latency
  always @(posedge clk_i) begin
    if (ram_en_o) begin
      if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
      else          ram_rdata_i     <= mem[ram_addr_o];
    end
  end

  // Hang guard
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [RW-1:0] ident(input int i);
    logic [RW-1:0] one = RW'(1);
    return one << (16*i);
  endfunction

  function automatic logic [RW-1:0] row_pat(input int i);
    return 64'hA5A5_0000_0000_0000 ^ (64'(i+1) * 64'h0000_0101_0101_0101);
  endfunction

  function automatic logic [RW-1:0] col_pat(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i+1);
  endfunction

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Compare DUT activity in the current cycle against the scoreboards
  task automatic monitor();
    exp_t e;
    if (inv_start_o) start_cnt++;
    if (inv_flush_o) flush_cnt++;
    if (ram_en_o && ram_we_o) begin
      check_output("ram_write_expected", 128'(exp_wr.size() != 0), 128'(1));
      if (exp_wr.size() != 0) begin
        e = exp_wr.pop_front();
        check_output("ram_write_addr", 128'(ram_addr_o), 128'(e.addr));
        check_output("ram_write_data", 128'(ram_wdata_o), 128'(e.data));
        check_output("ram_write_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
    if (mat_row_valid_o) begin
      check_output("row_expected", 128'(exp_row.size() != 0), 128'(1));
      if (exp_row.size() != 0) begin
        e = exp_row.pop_front();
        check_output("row_addr", 128'(mat_row_addr_o), 128'(e.addr));
        check_output("row_data", 128'(mat_row_o), 128'(e.data));
        check_output("row_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
    if (host_rd_data_valid_o) begin
      check_output("host_rd_expected", 128'(exp_rd.size() != 0), 128'(1));
      if (exp_rd.size() != 0) begin
        e = exp_rd.pop_front();
        check_output("host_rd_data", 128'(host_rd_data_o), 128'(e.data));
        check_output("host_rd_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  endtask

  // Sample at the falling edge, then move to just after the next rising edge
  task automatic step();
    @(negedge clk_i);
    monitor();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic apply_stimulus_idle();
    job_go_i = 0; job_flush_i = 0; job_ack_i = 0;
    host_wr_valid_i = 0; host_wr_addr_i = '0; host_wr_data_i = '0;
    host_rd_valid_i = 0; host_rd_addr_i = '0;
    inv_row_req_valid_i = 0; inv_row_req_addr_i = '0;
    inv_col_valid_i = 0; inv_col_addr_i = '0; inv_col_i = '0;
    inv_busy_i = 0;
  endtask

  task automatic do_reset();
    apply_stimulus_idle();
    rst_ni = 0;
    step();
    step();
    check_output("reset_ctrl",
      128'({job_done_o, job_state_o, err_o, host_rd_data_valid_o, inv_start_o,
            inv_flush_o, inv_out_ready_o, mat_row_addr_o, mat_row_valid_o,
            ram_en_o, ram_we_o, ram_addr_o}), 128'(0));
    check_output("reset_data", 128'(host_rd_data_o | mat_row_o | ram_wdata_o), 128'(0));
    rst_ni = 1;
  endtask

  task automatic write_row(input int idx, input logic [RW-1:0] data);
    exp_t e;
    e.addr = AW'(idx); e.data = data; e.cyc = cyc;
    exp_wr.push_back(e);
    rows[idx] = data;
    host_wr_valid_i = 1; host_wr_addr_i = IW'(idx); host_wr_data_i = data;
    step();
    host_wr_valid_i = 0;
  endtask

  task automatic go();
    job_go_i = 1;
    step();
    job_go_i = 0;
  endtask

  task automatic request_row(input int idx, input int lat);
    exp_t e;
    e.addr = AW'(idx); e.data = rows[idx]; e.cyc = cyc + lat;
    exp_row.push_back(e);
    inv_row_req_valid_i = 1; inv_row_req_addr_i = IW'(idx);
    step();
    inv_row_req_valid_i = 0;
  endtask

  task automatic send_col(input int idx, input logic [RW-1:0] data);
    exp_t e;
    for (int k = 0; k < 10 && !inv_out_ready_o; k++) step();
    check_output("out_ready", 128'(inv_out_ready_o), 128'(1));
    e.addr = AW'(SIZE + idx); e.data = data; e.cyc = cyc + 1;
    exp_wr.push_back(e);
    inv_col_valid_i = 1; inv_col_addr_i = IW'(idx); inv_col_i = data;
    step();
    inv_col_valid_i = 0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 20 && !job_done_o; k++) step();
    check_output("done_reached", 128'(job_done_o), 128'(1));
  endtask

  task automatic check_queues_empty(input string tag);
    check_output(tag, 128'(exp_wr.size() + exp_row.size() + exp_rd.size()), 128'(0));
  endtask

  initial begin
    exp_t e;
    do_reset();

    // Identity job end to end
    for (int i = 0; i < SIZE; i++) write_row(i, ident(i));
    check_output("state_load", 128'(job_state_o), 128'(1));
    start_cnt = 0;
    go();
    check_output("state_run", 128'(job_state_o), 128'(2));
    check_output("start_pulse", 128'(inv_start_o), 128'(1));
    inv_busy_i = 1;
    for (int i = 0; i < SIZE; i++) begin
      request_row(i, 3);
      step(); step(); step();
      send_col(i, ident(i));
      step();
    end
    inv_busy_i = 0;
    wait_done();
    check_output("state_done", 128'(job_state_o), 128'(3));
    check_output("start_count", 128'(start_cnt), 128'(1));
    for (int j = 0; j < SIZE; j++) begin
      e.addr = AW'(SIZE + j); e.data = ident(j); e.cyc = cyc + 2;
      exp_rd.push_back(e);
      host_rd_valid_i = 1; host_rd_addr_i = IW'(j);
      step();
    end
    host_rd_valid_i = 0;
    step(); step(); step();
    check_queues_empty("job1_queues_empty");
    check_output("job1_no_err", 128'(err_o), 128'(0));
    job_ack_i = 1;
    step();
    job_ack_i = 0;
    check_output("ack_to_idle", 128'(job_state_o), 128'(0));

    // Incomplete mask rejects job_go
    do_reset();
    for (int i = 0; i < SIZE-1; i++) write_row(i, row_pat(i));
    go();
    check_output("go_incomplete_err", 128'(err_o), 128'(1));
    check_output("go_incomplete_state", 128'(job_state_o), 128'(1));
    write_row(SIZE-1, row_pat(SIZE-1));
    go();
    check_output("go_complete_state", 128'(job_state_o), 128'(2));
    inv_busy_i = 1;

    // Writeback wins over a same-cycle row fetch
    check_output("ready_before_collision", 128'(inv_out_ready_o), 128'(1));
    e.addr = AW'(SIZE + 2); e.data = col_pat(2); e.cyc = cyc + 1;
    exp_wr.push_back(e);
    e.addr = AW'(1); e.data = rows[1]; e.cyc = cyc + 4;
    exp_row.push_back(e);
    inv_col_valid_i = 1; inv_col_addr_i = 2'd2; inv_col_i = col_pat(2);
    inv_row_req_valid_i = 1; inv_row_req_addr_i = 2'd1;
    step();
    inv_col_valid_i = 0; inv_row_req_valid_i = 0;
    step(); step(); step(); step();
    check_queues_empty("collision_queues_empty");

    // Second row request while the fetch slot is still full
    do_reset();
    for (int i = 0; i < SIZE; i++) write_row(i, row_pat(i));
    go();
    inv_busy_i = 1;
    e.addr = AW'(SIZE); e.data = col_pat(0); e.cyc = cyc + 1;
    exp_wr.push_back(e);
    e.addr = AW'(2); e.data = rows[2]; e.cyc = cyc + 4;
    exp_row.push_back(e);
    inv_col_valid_i = 1; inv_col_addr_i = 2'd0; inv_col_i = col_pat(0);
    inv_row_req_valid_i = 1; inv_row_req_addr_i = 2'd2;
    step();
    inv_col_valid_i = 0;
    check_output("first_req_no_err", 128'(err_o), 128'(0));
    inv_row_req_addr_i = 2'd3;
    step();
    inv_row_req_valid_i = 0;
    check_output("overflow_err", 128'(err_o), 128'(1));
    step(); step(); step(); step();
    check_queues_empty("overflow_queues_empty");

    // Flush in RUN with a row read already issued
    send_col(1, col_pat(1));
    step();
    flush_cnt = 0;
    inv_row_req_valid_i = 1; inv_row_req_addr_i = 2'd0;
    step();
    inv_row_req_valid_i = 0;
    step();
    job_flush_i = 1;
    step();
    job_flush_i = 0;
    check_output("flush_pulse", 128'(inv_flush_o), 128'(1));
    check_output("flush_state_idle", 128'(job_state_o), 128'(0));
    check_output("flush_no_row", 128'(mat_row_valid_o), 128'(0));
    step();
    check_output("flush_pulse_end", 128'(inv_flush_o), 128'(0));
    step(); step();
    check_output("flush_count", 128'(flush_cnt), 128'(1));
    inv_busy_i = 0;

    // Column counter restarts after the flush
    for (int i = 0; i < SIZE; i++) write_row(i, row_pat(i));
    start_cnt = 0;
    go();
    check_output("restart_start", 128'(inv_start_o), 128'(1));
    send_col(0, col_pat(0));
    send_col(1, col_pat(1));
    step(); step(); step();
    check_output("two_cols_not_done", 128'(job_done_o), 128'(0));
    check_output("two_cols_state", 128'(job_state_o), 128'(2));

    // Reset while in DONE
    send_col(2, col_pat(2));
    send_col(3, col_pat(3));
    step();
    wait_done();
    check_output("done_err_sticky", 128'(err_o), 128'(1));
    check_output("restart_start_count", 128'(start_cnt), 128'(1));
    check_queues_empty("final_queues_empty");
    do_reset();
    check_output("reset_err_cleared", 128'(err_o), 128'(0));
    check_output("reset_state_idle", 128'(job_state_o), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tri_inv_seq.md
# tri_inv_seq

Job sequencer and memory arbiter for the triangular matrix inverter. It owns one single-port row RAM of 2*SIZE rows: rows 0..SIZE-1 hold the upper-triangular input matrix and rows SIZE..2*SIZE-1 hold the inverse columns. It arbitrates that port between host load/unload, inverter row fetches and inverter column writebacks. It also sequences the inverter through load, start, run, completion and flush.

## Interface
Parameters:
- SIZE, 16, matrix dimension (power of two, at least 2)
- WIDTH, 64, bits per real/imag part; row width RW = SIZE*2*WIDTH, element j = {imag, real} at bits [j*2*WIDTH +: 2*WIDTH]
- AW, $clog2(2*SIZE), RAM address width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous active-low
- job_go_i  in  1  start a job; accepted only in LOAD when SIZE distinct rows have been written
- job_flush_i  in  1  abort the current job from any state
- job_done_o  out  1  high in DONE
- job_state_o  out  2  IDLE=0, LOAD=1, RUN=2, DONE=3
- err_o  out  1  sticky protocol error; cleared only by reset
- host_wr_valid_i  in  1  host row write
- host_wr_addr_i  in  $clog2(SIZE)  input row index
- host_wr_data_i  in  RW  row data
- host_rd_valid_i  in  1  host inverse-column read; honoured in DONE only
- host_rd_addr_i  in  $clog2(SIZE)  column index
- host_rd_data_o  out  RW  read data
- host_rd_data_valid_o  out  1  read data strobe
- job_ack_i  in  1  in DONE, return to IDLE
- inv_start_o  out  1  one-cycle start pulse to inverter
- inv_flush_o  out  1  one-cycle flush pulse to inverter
- inv_out_ready_o  out  1  writeback slot free
- inv_row_req_addr_i  in  $clog2(SIZE)  inverter row-fetch address
- inv_row_req_valid_i  in  1  inverter row-fetch request (pulse)
- mat_row_o  out  RW  fetched row
- mat_row_addr_o  out  $clog2(SIZE)  fetched row index
- mat_row_valid_o  out  1  fetched row strobe
- inv_col_i  in  RW  inverse column
- inv_col_addr_i  in  $clog2(SIZE)  column index
- inv_col_valid_i  in  1  column valid
- inv_busy_i  in  1  inverter busy
- ram_en_o  out  1  RAM port enable
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  AW  RAM address
- ram_wdata_o  out  RW  RAM write data
- ram_rdata_i  in  RW  RAM read data, valid 1 cycle after a read enable

## Operation
- FSM states and transitions:
  - IDLE→LOAD on the first host_wr_valid_i. That write is performed.
  - LOAD: each write goes to RAM row host_wr_addr_i and sets bit addr of a SIZE-bit loaded mask.
  - LOAD→RUN on job_go_i with the mask all ones. Pulse inv_start_o in the first RUN cycle.
  - job_go_i with an incomplete mask: set err_o and stay in LOAD.
  - RUN→DONE when col_cnt == SIZE and inv_busy_i == 0.
  - DONE→IDLE on job_ack_i. This clears the mask, col_cnt and pending slots.
- job_flush_i (any state, highest priority): next state IDLE. Pulse inv_flush_o for 1 cycle if the state was RUN. Clear the mask, counters and both pending slots. Suppress any mat_row_valid_o not yet issued.
- RUN pending slots, one entry each:
  - WB slot: captures {inv_col_addr_i, inv_col_i} when inv_col_valid_i and inv_out_ready_o are both high. inv_out_ready_o = RUN && !wb_full.
  - RD slot: captures inv_row_req_addr_i on inv_row_req_valid_i. A request arriving while RD is full sets err_o and is dropped.
- RAM arbitration, one access per cycle:
  - RUN: WB before RD. A WB write goes to address SIZE + col addr and increments col_cnt. Draining a slot frees it the same cycle; the slot can be refilled the next cycle.
  - LOAD/IDLE: host writes only. DONE: host reads only, to address SIZE + host_rd_addr_i.
  - Host writes outside IDLE/LOAD and host reads outside DONE are ignored and set err_o.
- inv_col_valid_i outside RUN sets err_o and is ignored.
- Row-fetch return: the registered outputs mat_row_o = ram_rdata_i, mat_row_addr_o = the captured address, and mat_row_valid_o rise together.

## Timing
- Reset (rst_ni low at a clock edge): state IDLE. All outputs are 0, including err_o, inv_out_ready_o and ram_en_o.
- Row fetch:
  - Request at cycle t with WB empty: RAM read at t+1, mat_row_valid_o at t+3.
  - If WB drains at t+1: read at t+2, mat_row_valid_o at t+4.
- Writeback: column accepted at t, RAM write at t+1 (RD waits), inv_out_ready_o high again at t+2.
- Host read in DONE: request at t, host_rd_data_valid_o at t+2.
- inv_start_o: exactly one pulse per job. inv_flush_o: exactly one pulse per flush from RUN.
- job_done_o rises in the cycle after the completion condition holds.

## Test plan
- Load a SIZE=4 identity matrix, then job_go_i. A behavioural inverter model fetches rows 0..3 and returns columns 0..3. Required: inv_start_o is a single pulse, RAM writes go to addresses 4..7, job_done_o rises, and host reads return the columns.
- Load 3 of 4 rows, then job_go_i → err_o=1 and state stays LOAD. Write row 3, then job_go_i → RUN.
- Same cycle: column 2 valid plus row request 1. Required: the write to RAM address 6 happens first, the read of row 1 the next cycle, and mat_row_valid_o with addr 1 at t+4.
- Two row requests on consecutive cycles while WB is busy → err_o=1 and the second request is dropped.
- job_flush_i mid-RUN after 2 columns → one inv_flush_o pulse, state IDLE, col_cnt=0, and no further mat_row_valid_o.
- Reset asserted in DONE → all outputs 0, state IDLE, and err_o cleared.
